// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: requester indices and FSM encoding.
package mem_port_arbiter_pkg;

    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] REQ_WEIGHT = 2'd0;
    localparam logic [1:0] REQ_IFMAP  = 2'd1;
    localparam logic [1:0] REQ_OFMAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Round-robin successor of a requester index, wrapping ofmap back to weight.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == REQ_OFMAP) ? REQ_WEIGHT : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker with an ofmap urgency override; purely combinational.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    input  logic       urgent,
    output logic [1:0] winner_c,
    output logic       any_req_c
);
    import mem_port_arbiter_pkg::*;

    // Scan starts at rr_ptr; winner is don't-care when no request is pending.
    always_comb begin
        winner_c  = REQ_WEIGHT;
        any_req_c = |req;
        if (urgent && req[REQ_OFMAP]) begin
            winner_c = REQ_OFMAP;
        end else begin
            case (rr_ptr)
                REQ_IFMAP: winner_c = req[REQ_IFMAP]  ? REQ_IFMAP  :
                                      req[REQ_OFMAP]  ? REQ_OFMAP  : REQ_WEIGHT;
                REQ_OFMAP: winner_c = req[REQ_OFMAP]  ? REQ_OFMAP  :
                                      req[REQ_WEIGHT] ? REQ_WEIGHT : REQ_IFMAP;
                default:   winner_c = req[REQ_WEIGHT] ? REQ_WEIGHT :
                                      req[REQ_IFMAP]  ? REQ_IFMAP  : REQ_OFMAP;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single off-chip memory port between weight, ifmap and ofmap burst engines,
// locking the port for a whole burst and issuing one address beat per accepted cycle.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned NUM_REQ    = mem_port_arbiter_pkg::NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic                          ofmap_urgent,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            beat,
    output logic [NUM_REQ-1:0]            done,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_last,
    output logic                          busy
);
    import mem_port_arbiter_pkg::*;

    // One extra bit so a max-length burst can count past len without wrapping.
    localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;

    state_t                state, state_nxt;
    logic [1:0]            owner, owner_nxt;
    logic [1:0]            rr_ptr, rr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [LEN_WIDTH-1:0]  len, len_nxt;
    logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
    logic [1:0]            winner_c;
    logic                  any_req_c;
    logic                  last_c;

    rr_pick3 u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .urgent    (ofmap_urgent),
        .winner_c  (winner_c),
        .any_req_c (any_req_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= REQ_WEIGHT;
            rr_ptr   <= REQ_WEIGHT;
            base     <= '0;
            len      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            base     <= base_nxt;
            len      <= len_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state and port outputs; beat/done follow the handshake in the same cycle.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        base_nxt     = base;
        len_nxt      = len;
        beat_cnt_nxt = beat_cnt;
        gnt          = '0;
        beat         = '0;
        done         = '0;
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_last     = 1'b0;
        busy         = (state != IDLE);
        last_c       = (beat_cnt == CNT_WIDTH'(len));

        case (state)
            IDLE: begin
                if (any_req_c) begin
                    owner_nxt    = winner_c;
                    base_nxt     = req_addr[winner_c*ADDR_WIDTH +: ADDR_WIDTH];
                    len_nxt      = req_len[winner_c*LEN_WIDTH +: LEN_WIDTH];
                    beat_cnt_nxt = '0;
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                gnt[owner] = 1'b1;
                mem_valid  = 1'b1;
                mem_we     = (owner == REQ_OFMAP);
                mem_addr   = base + ADDR_WIDTH'(beat_cnt);
                mem_last   = last_c;
                if (mem_ready) begin
                    beat[owner]  = 1'b1;
                    beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
                    if (last_c) begin
                        done[owner] = 1'b1;
                        state_nxt   = TURN;
                    end
                end
            end
            TURN: begin
                rr_ptr_nxt = rr_next(owner);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the accelerator's single off-chip memory port between three burst requesters: the weight tile loader (read), the ifmap tile loader (read) and the ofmap drain (write). The conv controller sequences these engines around the double buffers. This block picks one requester, locks the port for that requester's whole burst, and generates one address beat per accepted cycle. It sits between the three DMA engines and the memory interface.

Parameters:
ADDR_WIDTH, 16, memory word address width
LEN_WIDTH, 8, burst length field width; len = beats - 1
NUM_REQ, 3, number of requesters; fixed at 3 (0 = weight, 1 = ifmap, 2 = ofmap)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester burst request; held until done
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester burst base address; requester i uses slice i
req_len  in  NUM_REQ*LEN_WIDTH  per-requester beats-1; requester i uses slice i
ofmap_urgent  in  1  ofmap drain must win the next arbitration
gnt  out  NUM_REQ  one-hot; high for the full burst of the owner
beat  out  NUM_REQ  one-hot pulse on each accepted beat of the owner
done  out  NUM_REQ  one-hot pulse on the owner's last accepted beat
mem_valid  out  1  beat command valid
mem_ready  in  1  memory accepts the beat this cycle
mem_we  out  1  1 = write (ofmap owner), 0 = read
mem_addr  out  ADDR_WIDTH  beat address
mem_last  out  1  current beat is the last of the burst
busy  out  1  state != IDLE

Behaviour:
- Reset value of every output is 0. Internal state on reset: state = IDLE, rr_ptr = 0 (weight has highest priority first), beat_cnt = 0.
- States:
  - IDLE:
    - If any req, choose a winner and latch its index, addr and len. Go to BURST.
    - Otherwise stay in IDLE.
    - gnt rises on the cycle after the winning req is sampled (1-cycle arbitration latency).
  - BURST:
    - gnt[owner] = 1, mem_valid = 1, mem_we = (owner == 2).
    - mem_addr = base + beat_cnt, modulo 2^ADDR_WIDTH (wraps silently).
    - mem_last = (beat_cnt == len).
    - On mem_valid & mem_ready: pulse beat[owner] combinationally in the same cycle, and beat_cnt increments.
    - If that accepted beat is the last one: pulse done[owner] in the same cycle and go to TURN.
    - mem_ready low: hold all outputs and beat_cnt unchanged (stall of any length).
  - TURN:
    - One dead cycle with gnt = 0 and mem_valid = 0.
    - rr_ptr = (owner + 1) mod 3.
    - Go to IDLE.
    - Minimum gap between bursts is therefore 2 cycles (TURN, then IDLE arbitration).
- Winner selection:
  - If ofmap_urgent & req[2], the ofmap drain wins.
  - Otherwise the winner is the first set req at or after rr_ptr, scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- Beat count: len is sampled at grant, so len = 0 gives one beat and len = 2^LEN_WIDTH-1 gives 2^LEN_WIDTH beats. beat_cnt is LEN_WIDTH+1 bits wide, and len = max must not overflow it.
- req_addr, req_len and req changes during BURST are ignored. A deasserted req mid-burst does not abort the burst; the burst completes.
- req held high after done is re-arbitrated as a new burst; round-robin lets the other requesters in first.
- Simultaneous last beat and a new req from another requester: the new req is arbitrated only in IDLE, after TURN.
- Reset mid-burst: the next cycle is IDLE with all outputs 0. No done pulse is issued, and the partial burst is abandoned.
- ofmap_urgent affects arbitration only. It never preempts an in-flight burst.

Decomposition:
- Shared package holds:
  - REQ_WEIGHT = 0, REQ_IFMAP = 1, REQ_OFMAP = 2, NUM_REQ = 3
  - state encoding: IDLE = 0, BURST = 1, TURN = 2, on a 2-bit width
- One natural sub-module, rr_pick3: purely combinational. Takes req[2:0], rr_ptr and urgent; returns winner index and any_req. It is reused by other shared-resource arbiters.

Test Plan:
1. Single burst: req = 001, addr = 0x0100, len = 3, mem_ready = 1 → gnt[0] from cycle 1. Addresses 0x0100–0x0103 on cycles 1–4 with beat[0] on each, mem_last and done[0] on cycle 4, TURN on cycle 5, busy = 0 on cycle 6.
2. Contention: all three req asserted at reset exit with len = 0 and each held until its own done → grant order weight, ifmap, ofmap. Weight then wins again next (rr_ptr = 0). mem_we = 1 only during the ofmap burst.
3. Stall: len = 2, mem_ready toggling 1,0,0,1,0,1 → addresses advance only on ready cycles, beat count = 3, outputs stable during stalls.
4. Urgent override: rr_ptr = 0, req = 111, ofmap_urgent = 1 → ofmap granted first. Next arbitration with urgent = 0 picks weight (rr_ptr = 0 after ofmap).
5. Address wrap and max length: addr = 0xFFFE, len = 3 → 0xFFFE, 0xFFFF, 0x0000, 0x0001. A separate len = 255 run → exactly 256 beats and a single done.
6. Reset mid-burst: assert rst on beat 2 of a len = 7 burst → next cycle all outputs 0, no done. A subsequent req = 010 is served normally with rr_ptr = 0.
